result_collector: RTL

Downstream collection stage of the floating-point co-processor. Captures single-cycle done pulses and results from the add/sub, multiply and sine/cosine units, arbitrates them into an in-order result FIFO, and presents the FIFO head to the CPU via a valid/acknowledge handshake. Drives `out_fifo_hold` back to the input decoder so that no new operation is issued unless every in-flight result has a guaranteed slot.

---
 rtl/fp_pkg.sv | 25 ++
 rtl/fp_sync_fifo.sv | 54 +++++
 rtl/result_collector.sv | 130 +++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared types for the floating-point co-processor result path.
package fp_pkg;

  localparam int FP_WIDTH = 32;
  localparam int NUM_SRC  = 3;

  typedef enum logic [1:0] {
    SRC_ADD  = 2'd0,
    SRC_MUL  = 2'd1,
    SRC_TRIG = 2'd2
  } src_tag_t;

  typedef struct packed {
    logic                overflow;
    src_tag_t            tag;
    logic [FP_WIDTH-1:0] data;
  } result_entry_t;

  // Value parked in a per-source holding register before it is queued.
  typedef struct packed {
    logic                overflow;
    logic [FP_WIDTH-1:0] data;
  } hold_val_t;

endpackage

// File: rtl/fp_sync_fifo.sv
// Synchronous FIFO with registered count; push is ignored when full, pop when empty.
module fp_sync_fifo #(
  parameter int  DEPTH   = 8,
  parameter type entry_t = logic [34:0],
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          push,
  input  entry_t        wr_data,
  input  logic          pop,
  output entry_t        rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;
  entry_t        mem_q [DEPTH];

  always_comb begin
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    // Pointers wrap naturally because DEPTH is a power of two.
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/result_collector.sv
// Collects add/mul/trig results into an in-order FIFO and presents the head to the CPU.
module result_collector
  import fp_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int HOLD_MARGIN = 3,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                add_done,
  input  logic [FP_WIDTH-1:0] add_result,
  input  logic                add_overflow,
  input  logic                mul_done,
  input  logic [FP_WIDTH-1:0] mul_result,
  input  logic                mul_overflow,
  input  logic                trig_done,
  input  logic [FP_WIDTH-1:0] trig_result,
  input  logic                rd_ack,
  output logic [FP_WIDTH-1:0] result,
  output logic                overflow,
  output logic [1:0]          src_tag,
  output logic                done,
  output logic                out_fifo_hold,
  output logic                lost_result
);

  // CPU handshake: done=1 means the head entry is valid on result/overflow/src_tag;
  // rd_ack in a cycle with done=1 consumes it at the next edge, rd_ack with done=0 is ignored.

  hold_val_t            hold_q [NUM_SRC];
  hold_val_t            hold_d [NUM_SRC];
  logic [NUM_SRC-1:0]   occ_q, occ_d;
  logic                 lost_q, lost_d;

  logic [NUM_SRC-1:0]   src_done;
  hold_val_t            src_val [NUM_SRC];
  logic [NUM_SRC-1:0]   grant;
  result_entry_t        push_entry;
  logic                 push;

  result_entry_t        head;
  logic                 fifo_full, fifo_empty;
  logic [AW:0]          fifo_count;
  logic [1:0]           occ_cnt;
  int                   used_slots;

  always_comb begin
    src_done   = {trig_done, mul_done, add_done};
    src_val[0] = '{overflow: add_overflow, data: add_result};
    src_val[1] = '{overflow: mul_overflow, data: mul_result};
    src_val[2] = '{overflow: 1'b0,         data: trig_result};
  end

  // Fixed priority add > mul > trig; the full check uses registered count, so a
  // slot freed by a pop this cycle is only usable next cycle.
  always_comb begin
    grant      = '0;
    push_entry = '0;
    if (!fifo_full) begin
      if (occ_q[0]) begin
        grant      = 3'b001;
        push_entry = '{overflow: hold_q[0].overflow, tag: SRC_ADD, data: hold_q[0].data};
      end else if (occ_q[1]) begin
        grant      = 3'b010;
        push_entry = '{overflow: hold_q[1].overflow, tag: SRC_MUL, data: hold_q[1].data};
      end else if (occ_q[2]) begin
        grant      = 3'b100;
        push_entry = '{overflow: hold_q[2].overflow, tag: SRC_TRIG, data: hold_q[2].data};
      end
    end
    push = |grant;
  end

  always_comb begin
    lost_d = lost_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      hold_d[i] = hold_q[i];
      occ_d[i]  = occ_q[i] & ~grant[i];
      if (src_done[i]) begin
        if (occ_q[i] && !grant[i]) begin
          lost_d = 1'b1;
        end else begin
          hold_d[i] = src_val[i];
          occ_d[i]  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < NUM_SRC; i++) hold_q[i] <= '0;
      occ_q  <= '0;
      lost_q <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) hold_q[i] <= hold_d[i];
      occ_q  <= occ_d;
      lost_q <= lost_d;
    end
  end

  fp_sync_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (result_entry_t)
  ) u_fifo (
    .clk     (clk),
    .n_rst   (n_rst),
    .push    (push),
    .wr_data (push_entry),
    .pop     (rd_ack & done),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    occ_cnt    = 2'(occ_q[0]) + 2'(occ_q[1]) + 2'(occ_q[2]);
    used_slots = int'(fifo_count) + int'(occ_cnt);
  end

  assign done          = ~fifo_empty;
  assign result        = done ? head.data : '0;
  assign overflow      = done ? head.overflow : 1'b0;
  assign src_tag       = done ? head.tag : 2'd0;
  assign out_fifo_hold = (used_slots >= (DEPTH - HOLD_MARGIN));
  assign lost_result   = lost_q;

endmodule
